// File: rtl/regfile_param.sv
// Parametrised RV32I integer register file: hardwired-zero x0, sequential clear sweep,
// handshaked debug port. Define REGFILE_BYPASS_EN for write-to-read bypass on the read ports.
module regfile_param #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   ReadRegNum1,
    output logic [XLEN-1:0] ReadRegData1,
    input  logic [AW-1:0]   ReadRegNum2,
    output logic [XLEN-1:0] ReadRegData2,
    input  logic [AW-1:0]   WriteRegNum,
    input  logic [XLEN-1:0] WriteRegData,
    input  logic            RegWrite,
    input  logic            ClearReq,
    output logic            Busy,
    input  logic            DbgValid,
    input  logic            DbgWrite,
    input  logic [AW-1:0]   DbgAddr,
    input  logic [XLEN-1:0] DbgWData,
    output logic            DbgReady,
    output logic            DbgRValid,
    output logic [XLEN-1:0] DbgRData
);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t          state, next_state;
    logic [AW-1:0]   ptr, next_ptr;
    logic [XLEN-1:0] regs [NREGS];

    logic            core_we;
    logic            dbg_xfer;
    logic            dbg_we;
    logic            dbg_re;
    logic [XLEN-1:0] stored1;
    logic [XLEN-1:0] stored2;
    logic [XLEN-1:0] dbg_stored;

    always_comb begin
        next_state = state;
        next_ptr   = ptr;
        DbgReady   = 1'b0;
        core_we    = 1'b0;
        case (state)
            IDLE: begin
                // The core owns the array whenever it writes or asks for a clear.
                DbgReady = !RegWrite && !ClearReq;
                core_we  = RegWrite && (WriteRegNum != '0);
                if (ClearReq) begin
                    next_state = CLEAR;
                    next_ptr   = AW'(1);
                end
            end
            CLEAR: begin
                if (ptr == AW'(NREGS - 1)) begin
                    next_state = IDLE;
                end else begin
                    next_ptr = ptr + AW'(1);
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign dbg_xfer = DbgValid && DbgReady;
    assign dbg_we   = dbg_xfer && DbgWrite && (DbgAddr != '0);
    assign dbg_re   = dbg_xfer && !DbgWrite;
    assign Busy     = (state == CLEAR);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= CLEAR;
            ptr   <= AW'(1);
        end else begin
            state <= next_state;
            ptr   <= next_ptr;
        end
    end

    // Reset never touches the array; entry 0 is never written and is masked on read.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == CLEAR) begin
                regs[ptr] <= '0;
            end else if (core_we) begin
                regs[WriteRegNum] <= WriteRegData;
            end else if (dbg_we) begin
                regs[DbgAddr] <= DbgWData;
            end
        end
    end

    always_comb begin
        stored1    = (ReadRegNum1 == '0) ? '0 : regs[ReadRegNum1];
        stored2    = (ReadRegNum2 == '0) ? '0 : regs[ReadRegNum2];
        dbg_stored = (DbgAddr == '0)     ? '0 : regs[DbgAddr];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            DbgRValid <= 1'b0;
            DbgRData  <= '0;
        end else begin
            DbgRValid <= dbg_re;
            if (dbg_re) begin
                DbgRData <= dbg_stored;
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign ReadRegData1 = (core_we && (WriteRegNum == ReadRegNum1)) ? WriteRegData : stored1;
    assign ReadRegData2 = (core_we && (WriteRegNum == ReadRegNum2)) ? WriteRegData : stored2;
`else
    assign ReadRegData1 = stored1;
    assign ReadRegData2 = stored2;
`endif

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param (default 32x32 build); debug read data is
// checked through a scoreboard queue filled when each read is accepted.
module tb_regfile_param;

    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] ReadRegNum1, ReadRegNum2, WriteRegNum, DbgAddr;
    logic [31:0]   ReadRegData1, ReadRegData2, WriteRegData, DbgWData, DbgRData;
    logic          RegWrite, ClearReq, Busy, DbgValid, DbgWrite, DbgReady, DbgRValid;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] mdl [32];
    logic [31:0] sb [$];

    regfile_param dut (
        .clk(clk), .rst_n(rst_n),
        .ReadRegNum1(ReadRegNum1), .ReadRegData1(ReadRegData1),
        .ReadRegNum2(ReadRegNum2), .ReadRegData2(ReadRegData2),
        .WriteRegNum(WriteRegNum), .WriteRegData(WriteRegData), .RegWrite(RegWrite),
        .ClearReq(ClearReq), .Busy(Busy),
        .DbgValid(DbgValid), .DbgWrite(DbgWrite), .DbgAddr(DbgAddr), .DbgWData(DbgWData),
        .DbgReady(DbgReady), .DbgRValid(DbgRValid), .DbgRData(DbgRData)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [AW-1:0] num, input logic [31:0] data, input logic clr);
        RegWrite     = we;
        WriteRegNum  = num;
        WriteRegData = data;
        ClearReq     = clr;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic core_write(input logic [AW-1:0] a, input logic [31:0] d);
        applyStimulus(1'b1, a, d, 1'b0);
        cycle();
        if (a != 0) mdl[a] = d;
        applyStimulus(1'b0, '0, '0, 1'b0);
    endtask

    task automatic dbg_access(input logic wr, input logic [AW-1:0] a, input logic [31:0] d);
        bit done = 0;
        DbgValid = 1'b1;
        DbgWrite = wr;
        DbgAddr  = a;
        DbgWData = d;
        for (int k = 0; k < 50 && !done; k++) begin
            #1;
            if (DbgReady === 1'b1) begin
                if (!wr) sb.push_back(mdl[a]);
                done = 1;
            end
            cycle();
        end
        if (done && wr && a != 0) mdl[a] = d;
        DbgValid = 1'b0;
        DbgWrite = 1'b0;
        if (!done) checkOutput("dbg_timeout", 32'd0, 32'd1);
    endtask

    task automatic count_busy(output int n);
        n = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (Busy !== 1'b1) break;
            n++;
        end
    endtask

    task automatic check_all_regs(input string tag);
        for (int i = 1; i < 32; i++) begin
            ReadRegNum1 = AW'(i);
            ReadRegNum2 = AW'(32 - i);
            #1;
            checkOutput({tag, "_p1"}, ReadRegData1, mdl[i]);
            checkOutput({tag, "_p2"}, ReadRegData2, mdl[32 - i]);
        end
    endtask

    always @(negedge clk) begin
        if (DbgRValid === 1'b1) begin
            if (sb.size() == 0) checkOutput("dbg_rvalid_spurious", 32'd1, 32'd0);
            else checkOutput("dbg_rdata", DbgRData, sb.pop_front());
        end
    end

    initial begin
        int n;
        for (int i = 0; i < 32; i++) mdl[i] = '0;
        rst_n = 1'b0;
        applyStimulus(1'b0, '0, '0, 1'b0);
        DbgValid = 0; DbgWrite = 0; DbgAddr = '0; DbgWData = '0;
        ReadRegNum1 = '0; ReadRegNum2 = '0;

        cycle();
        checkOutput("rst_busy", Busy, 1);
        checkOutput("rst_dbgready", DbgReady, 0);
        checkOutput("rst_rvalid", DbgRValid, 0);
        checkOutput("rst_rdata", DbgRData, 0);
        checkOutput("rst_x0", ReadRegData1, 0);
        cycle();
        cycle();
        rst_n = 1'b1;
        count_busy(n);
        checkOutput("reset_sweep_len", n, 31);
        check_all_regs("after_reset");
        #1 checkOutput("idle_dbgready", DbgReady, 1);

        // x0 is hardwired to zero for core, debug and both read ports.
        core_write(5'd0, 32'hDEADBEEF);
        dbg_access(1'b1, 5'd0, 32'h1);
        ReadRegNum1 = 5'd0; ReadRegNum2 = 5'd0;
        #1 checkOutput("x0_p1", ReadRegData1, 0);
        checkOutput("x0_p2", ReadRegData2, 0);
        dbg_access(1'b0, 5'd0, '0);

        ReadRegNum1 = 5'd5; ReadRegNum2 = 5'd6;
        applyStimulus(1'b1, 5'd5, 32'h12345678, 1'b0);
        #1;
`ifdef REGFILE_BYPASS_EN
        checkOutput("same_cycle_x5", ReadRegData1, 32'h12345678);
`else
        checkOutput("same_cycle_x5", ReadRegData1, 32'h0);
`endif
        checkOutput("same_cycle_other_port", ReadRegData2, 32'h0);
        cycle();
        mdl[5] = 32'h12345678;
        applyStimulus(1'b0, '0, '0, 1'b0);
        #1 checkOutput("next_cycle_x5", ReadRegData1, 32'h12345678);

        // Debug read held while the core writes: refused, then accepted next cycle.
        DbgValid = 1'b1; DbgWrite = 1'b0; DbgAddr = 5'd5;
        applyStimulus(1'b1, 5'd6, 32'hA5A5A5A5, 1'b0);
        #1 checkOutput("arb_ready_low", DbgReady, 0);
        cycle();
        mdl[6] = 32'hA5A5A5A5;
        applyStimulus(1'b0, '0, '0, 1'b0);
        #1 checkOutput("arb_ready_high", DbgReady, 1);
        checkOutput("arb_rvalid_early", DbgRValid, 0);
        sb.push_back(mdl[5]);
        cycle();
        DbgValid = 1'b0;
        #1 checkOutput("arb_rvalid", DbgRValid, 1);
        cycle();
        checkOutput("arb_rvalid_pulse", DbgRValid, 0);
        checkOutput("arb_rdata_hold", DbgRData, 32'h12345678);
        ReadRegNum2 = 5'd6;
        #1 checkOutput("x6_after_write", ReadRegData2, 32'hA5A5A5A5);

        dbg_access(1'b1, 5'd7, 32'hCAFEF00D);
        ReadRegNum2 = 5'd7;
        #1 checkOutput("dbg_write_x7", ReadRegData2, 32'hCAFEF00D);
        dbg_access(1'b0, 5'd7, '0);

        for (int i = 1; i < 32; i++) core_write(AW'(i), 32'hA000_0000 | (i * 32'h0001_0203));
        dbg_access(1'b0, 5'd31, '0);
        check_all_regs("populated");

        // ClearReq with a simultaneous core write; the write must land before the sweep.
        applyStimulus(1'b1, 5'd3, 32'h33, 1'b1);
        cycle();
        mdl[3] = 32'h33;
        applyStimulus(1'b0, '0, '0, 1'b0);
        ReadRegNum1 = 5'd3;
        DbgValid = 1'b1; DbgWrite = 1'b1; DbgAddr = 5'd2; DbgWData = 32'hBAD0BAD0;
        #1 checkOutput("clr_write_kept", ReadRegData1, 32'h33);
        checkOutput("clr_dbgready", DbgReady, 0);
        n = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (Busy !== 1'b1) break;
            if (c == 5) ClearReq = 1'b1;
            if (c == 6) ClearReq = 1'b0;
            if (c == 10) begin
                ReadRegNum1 = 5'd10; ReadRegNum2 = 5'd11;
                #1 checkOutput("mid_sweep_cleared", ReadRegData1, 32'h0);
                checkOutput("mid_sweep_pending", ReadRegData2, mdl[11]);
            end
            if (c == 12) applyStimulus(1'b1, 5'd1, 32'hBAD00001, 1'b0);
            if (c == 13) applyStimulus(1'b0, '0, '0, 1'b0);
            n++;
        end
        DbgValid = 1'b0; DbgWrite = 1'b0;
        checkOutput("clear_sweep_len", n, 31);
        for (int i = 1; i < 32; i++) mdl[i] = '0;
        check_all_regs("after_clear");

        applyStimulus(1'b0, '0, '0, 1'b1);
        cycle();
        applyStimulus(1'b0, '0, '0, 1'b0);
        for (int c = 0; c < 10; c++) @(negedge clk);
        rst_n = 1'b0;
        cycle();
        cycle();
        checkOutput("midsweep_rst_busy", Busy, 1);
        rst_n = 1'b1;
        count_busy(n);
        checkOutput("midsweep_rst_len", n, 31);

        dbg_access(1'b1, 5'd9, 32'h0BADF00D);
        dbg_access(1'b0, 5'd9, '0);
        dbg_access(1'b0, 5'd1, '0);
        cycle();
        cycle();
        checkOutput("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
